// File: rtl/wb_mailbox_pkg.sv
// ---------------------------------------------------------------------------
// wb_mailbox_pkg
//   Shared definitions for the Wishbone mailbox slave: register map selector,
//   ack handshake states, STATUS bit positions and IRQ_EN bit positions.
// ---------------------------------------------------------------------------
package wb_mailbox_pkg;

   // Register select taken from wbs_adr_i[3:2]
   typedef enum logic [1:0] {
      REG_M2C_DATA = 2'd0,
      REG_C2M_DATA = 2'd1,
      REG_STATUS   = 2'd2,
      REG_IRQ_EN   = 2'd3
   } reg_sel_e;

   // Bus response handshake
   typedef enum logic {
      ACK_IDLE = 1'b0,
      ACK_RESP = 1'b1
   } ack_state_e;

   // STATUS register layout
   localparam int unsigned ST_M2C_EMPTY   = 0;
   localparam int unsigned ST_M2C_FULL    = 1;
   localparam int unsigned ST_C2M_EMPTY   = 2;
   localparam int unsigned ST_C2M_FULL    = 3;
   localparam int unsigned ST_M2C_OVF     = 4;
   localparam int unsigned ST_C2M_UNF     = 5;
   localparam int unsigned ST_M2C_LVL_LSB = 16;
   localparam int unsigned ST_C2M_LVL_LSB = 24;

   // IRQ_EN register layout
   localparam int unsigned IRQ_RX_AVAIL = 0;
   localparam int unsigned IRQ_ERR      = 1;

   // Full-word byte enable required for data and IRQ_EN writes
   localparam logic [3:0] SEL_WORD = 4'hF;

endpackage

// File: rtl/mbx_sync_fifo.sv
// ---------------------------------------------------------------------------
// mbx_sync_fifo
//   Single-clock FIFO used for both mailbox directions.
//   clk, rst_n          : clock, async active-low reset (contents discarded)
//   push, push_data     : write request and data
//   pop                 : read request (ignored while empty)
//   head                : oldest entry (meaningless while empty)
//   full, empty, level  : occupancy flags and count (0..DEPTH)
// ---------------------------------------------------------------------------
module mbx_sync_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DW    = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [DW-1:0]            push_data,
   input  logic                     pop,
   output logic [DW-1:0]            head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW:0]   wptr_q;
   logic [AW:0]   rptr_q;
   logic          push_en;
   logic          pop_en;

   // Extra pointer MSB distinguishes full from empty when the indices match
   assign empty   = (wptr_q == rptr_q);
   assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign level   = wptr_q - rptr_q;
   assign head    = mem[rptr_q[AW-1:0]];

   // A simultaneous pop frees the slot, so a push into a full FIFO still lands
   assign pop_en  = pop & ~empty;
   assign push_en = push & (~full | pop_en);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push_en) wptr_q <= wptr_q + (AW+1)'(1);
         if (pop_en)  rptr_q <= rptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) mem[wptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/wb_mailbox_slave.sv
// ---------------------------------------------------------------------------
// wb_mailbox_slave
//   Wishbone classic responder giving the management core a two-way mailbox
//   to the darksocv core, with STATUS and IRQ_EN registers.
//   wb_clk_i, wb_rst_ni        : clock, async active-low reset
//   wbs_stb/cyc/we/sel/dat/adr : Wishbone request inputs
//   wbs_ack_o, wbs_dat_o       : one-cycle ack pulse with registered read data
//   m2c_data/valid/ready       : core-side M2C pop interface
//   c2m_data/valid/ready       : core-side C2M push interface
//   irq_o                      : level interrupt (rx available / error)
// ---------------------------------------------------------------------------
module wb_mailbox_slave
   import wb_mailbox_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned DW        = 32
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_ni,
   input  logic          wbs_stb_i,
   input  logic          wbs_cyc_i,
   input  logic          wbs_we_i,
   input  logic [3:0]    wbs_sel_i,
   input  logic [31:0]   wbs_dat_i,
   input  logic [31:0]   wbs_adr_i,
   output logic          wbs_ack_o,
   output logic [31:0]   wbs_dat_o,
   output logic [DW-1:0] m2c_data_o,
   output logic          m2c_valid_o,
   input  logic          m2c_ready_i,
   input  logic [DW-1:0] c2m_data_i,
   input  logic          c2m_valid_i,
   output logic          c2m_ready_o,
   output logic          irq_o
);

   localparam int unsigned LW = $clog2(DEPTH) + 1;

   ack_state_e     state_q, state_d;
   reg_sel_e       reg_sel;
   logic           hit, req, wr, rd, word_sel;

   logic           m2c_wr, m2c_push, m2c_pop, m2c_full, m2c_empty;
   logic [LW-1:0]  m2c_level;
   logic           c2m_rd, c2m_push, c2m_pop, c2m_full, c2m_empty;
   logic [LW-1:0]  c2m_level;
   logic [DW-1:0]  c2m_head;

   logic           ovf_q, unf_q, ovf_set, unf_set, ovf_clr, unf_clr, status_wr;
   logic [1:0]     irq_en_q;
   logic           irq_en_we;
   logic [31:0]    status_w, rdata_d;
   logic           unused_adr;

   // Byte offset inside a word carries no meaning for this register file
   assign unused_adr = ^wbs_adr_i[1:0];

   // ---------------- bus decode ----------------
   assign hit      = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
   // Only accepted while idle, which gives the mandatory gap between acks
   assign req      = wbs_stb_i & wbs_cyc_i & hit & (state_q == ACK_IDLE);
   assign wr       = req & wbs_we_i;
   assign rd       = req & ~wbs_we_i;
   assign reg_sel  = reg_sel_e'(wbs_adr_i[3:2]);
   assign word_sel = (wbs_sel_i == SEL_WORD);

   assign m2c_wr    = wr & (reg_sel == REG_M2C_DATA) & word_sel;
   assign m2c_push  = m2c_wr & ~m2c_full;
   assign ovf_set   = m2c_wr & m2c_full;

   assign c2m_rd    = rd & (reg_sel == REG_C2M_DATA);
   assign c2m_pop   = c2m_rd & ~c2m_empty;
   assign unf_set   = c2m_rd & c2m_empty;

   assign status_wr = wr & (reg_sel == REG_STATUS) & wbs_sel_i[0];
   assign ovf_clr   = status_wr & wbs_dat_i[ST_M2C_OVF];
   assign unf_clr   = status_wr & wbs_dat_i[ST_C2M_UNF];

   assign irq_en_we = wr & (reg_sel == REG_IRQ_EN) & word_sel;

   // ---------------- core side ----------------
   assign m2c_pop     = m2c_ready_i & ~m2c_empty;
   assign m2c_valid_o = ~m2c_empty;
   assign c2m_push    = c2m_valid_i & ~c2m_full;
   assign c2m_ready_o = ~c2m_full;

   mbx_sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_m2c_fifo (
      .clk       (wb_clk_i),
      .rst_n     (wb_rst_ni),
      .push      (m2c_push),
      .push_data (wbs_dat_i),
      .pop       (m2c_pop),
      .head      (m2c_data_o),
      .full      (m2c_full),
      .empty     (m2c_empty),
      .level     (m2c_level)
   );

   mbx_sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_c2m_fifo (
      .clk       (wb_clk_i),
      .rst_n     (wb_rst_ni),
      .push      (c2m_push),
      .push_data (c2m_data_i),
      .pop       (c2m_pop),
      .head      (c2m_head),
      .full      (c2m_full),
      .empty     (c2m_empty),
      .level     (c2m_level)
   );

   // ---------------- register read path ----------------
   always_comb begin
      status_w                          = '0;
      status_w[ST_M2C_EMPTY]            = m2c_empty;
      status_w[ST_M2C_FULL]             = m2c_full;
      status_w[ST_C2M_EMPTY]            = c2m_empty;
      status_w[ST_C2M_FULL]             = c2m_full;
      status_w[ST_M2C_OVF]              = ovf_q;
      status_w[ST_C2M_UNF]              = unf_q;
      status_w[ST_M2C_LVL_LSB +: 8]     = 8'(m2c_level);
      status_w[ST_C2M_LVL_LSB +: 8]     = 8'(c2m_level);
   end

   always_comb begin
      rdata_d = '0;
      unique case (reg_sel)
         REG_M2C_DATA: rdata_d = '0;
         REG_C2M_DATA: if (!c2m_empty) rdata_d = c2m_head;
         REG_STATUS:   rdata_d = status_w;
         REG_IRQ_EN:   rdata_d = {30'd0, irq_en_q};
      endcase
   end

   // ---------------- ack FSM ----------------
   always_comb begin
      state_d   = state_q;
      wbs_ack_o = 1'b0;
      unique case (state_q)
         ACK_IDLE: if (req) state_d = ACK_RESP;
         ACK_RESP: begin
            wbs_ack_o = 1'b1;
            state_d   = ACK_IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q   <= ACK_IDLE;
         wbs_dat_o <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         irq_en_q  <= '0;
         irq_o     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wbs_dat_o <= rd ? rdata_d : '0;
         // Set takes priority over a same-cycle W1C
         ovf_q     <= ovf_set | (ovf_q & ~ovf_clr);
         unf_q     <= unf_set | (unf_q & ~unf_clr);
         if (irq_en_we) irq_en_q <= wbs_dat_i[1:0];
         irq_o     <= (irq_en_q[IRQ_RX_AVAIL] & ~c2m_empty) |
                      (irq_en_q[IRQ_ERR] & (ovf_q | unf_q));
      end
   end

endmodule

// File: tb/tb_wb_mailbox_slave.sv
// ---------------------------------------------------------------------------
// tb_wb_mailbox_slave
//   Self-checking bench for wb_mailbox_slave: directed mailbox scenarios
//   followed by randomized bus/core traffic against a queue-based model.
// ---------------------------------------------------------------------------
module tb_wb_mailbox_slave;

   localparam logic [31:0] BASE  = 32'h3000_0000;
   localparam int unsigned DEPTH = 4;

   logic        clk, rst_n;
   logic        stb, cyc, we;
   logic [3:0]  sel;
   logic [31:0] wdat, adr;
   logic        ack;
   logic [31:0] rdat;
   logic [31:0] m2c_data;
   logic        m2c_valid, m2c_ready;
   logic [31:0] c2m_data;
   logic        c2m_valid, c2m_ready;
   logic        irq;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic [31:0] m2c_q[$];
   logic [31:0] c2m_q[$];
   logic        m_ovf, m_unf, m_ack, m_irq;
   logic [1:0]  m_irq_en;
   logic [31:0] m_dat;

   wb_mailbox_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .DW(32)) dut (
      .wb_clk_i    (clk),
      .wb_rst_ni   (rst_n),
      .wbs_stb_i   (stb),
      .wbs_cyc_i   (cyc),
      .wbs_we_i    (we),
      .wbs_sel_i   (sel),
      .wbs_dat_i   (wdat),
      .wbs_adr_i   (adr),
      .wbs_ack_o   (ack),
      .wbs_dat_o   (rdat),
      .m2c_data_o  (m2c_data),
      .m2c_valid_o (m2c_valid),
      .m2c_ready_i (m2c_ready),
      .c2m_data_i  (c2m_data),
      .c2m_valid_i (c2m_valid),
      .c2m_ready_o (c2m_ready),
      .irq_o       (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_status();
      logic [31:0] s;
      s        = '0;
      s[0]     = (m2c_q.size() == 0);
      s[1]     = (m2c_q.size() == DEPTH);
      s[2]     = (c2m_q.size() == 0);
      s[3]     = (c2m_q.size() == DEPTH);
      s[4]     = m_ovf;
      s[5]     = m_unf;
      s[23:16] = 8'(m2c_q.size());
      s[31:24] = 8'(c2m_q.size());
      return s;
   endfunction

   task automatic model_reset();
      m2c_q.delete();
      c2m_q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_ack = 1'b0; m_irq = 1'b0;
      m_irq_en = 2'b00; m_dat = '0;
   endtask

   // One rising edge of behaviour, decided entirely from pre-edge state
   task automatic model_step();
      int unsigned m_sz, c_sz;
      logic        req, irq_next, push_m2c, pop_c2m, set_ovf, set_unf, clr_ovf, clr_unf;
      logic [1:0]  en_next;
      logic [31:0] rd_val, st_pre;
      m_sz = m2c_q.size();
      c_sz = c2m_q.size();
      st_pre = model_status();
      req = stb && cyc && ((adr >> 4) == (BASE >> 4)) && !m_ack;
      irq_next = (m_irq_en[0] && c_sz != 0) || (m_irq_en[1] && (m_ovf || m_unf));
      push_m2c = 0; pop_c2m = 0; set_ovf = 0; set_unf = 0; clr_ovf = 0; clr_unf = 0;
      en_next = m_irq_en;
      rd_val = '0;
      if (req) begin
         case (adr[3:2])
            2'd0: if (we && sel == 4'hF) begin
                     if (m_sz < DEPTH) push_m2c = 1; else set_ovf = 1;
                  end
            2'd1: if (!we) begin
                     if (c_sz != 0) begin rd_val = c2m_q[0]; pop_c2m = 1; end
                     else set_unf = 1;
                  end
            2'd2: if (!we) rd_val = st_pre;
                  else if (sel[0]) begin clr_ovf = wdat[4]; clr_unf = wdat[5]; end
            default: if (!we) rd_val = {30'd0, m_irq_en};
                     else if (sel == 4'hF) en_next = wdat[1:0];
         endcase
      end
      if (m2c_ready && m_sz != 0) void'(m2c_q.pop_front());
      if (push_m2c) m2c_q.push_back(wdat);
      if (pop_c2m) void'(c2m_q.pop_front());
      if (c2m_valid && c_sz < DEPTH) c2m_q.push_back(c2m_data);
      m_ovf    = set_ovf | (m_ovf & !clr_ovf);
      m_unf    = set_unf | (m_unf & !clr_unf);
      m_irq_en = en_next;
      m_ack    = req;
      m_dat    = (req && !we) ? rd_val : 32'd0;
      m_irq    = irq_next;
   endtask

   task automatic compare_all();
      check("ack", 32'(ack), 32'(m_ack));
      check("dat_o", rdat, m_dat);
      check("m2c_valid", 32'(m2c_valid), 32'(m2c_q.size() != 0));
      if (m2c_q.size() != 0) check("m2c_data", m2c_data, m2c_q[0]);
      check("c2m_ready", 32'(c2m_ready), 32'(c2m_q.size() < DEPTH));
      check("irq", 32'(irq), 32'(m_irq));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rdata);
      int unsigned n;
      stb = 1; cyc = 1; we = w; adr = a; wdat = d; sel = s;
      n = 0;
      do begin
         tick();
         n++;
      end while (!ack && n < 4);
      check("ack_latency", n, 32'd1);
      rdata = rdat;
      stb = 0; cyc = 0; we = 0;
      tick();
      check("ack_pulse", 32'(ack), 32'd0);
   endtask

   logic [31:0] r;
   logic        seen_ack;

   initial begin
      rst_n = 0; stb = 0; cyc = 0; we = 0; sel = '0; wdat = '0; adr = '0;
      m2c_ready = 0; c2m_valid = 0; c2m_data = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #3 rst_n = 1;
      #1;
      compare_all();
      check("rst_c2m_ready", 32'(c2m_ready), 32'd1);

      // reset STATUS
      bus_xfer(0, BASE + 32'h8, '0, 4'hF, r);
      check("status_rst", r, 32'h0000_0005);

      // single M2C write and core pop
      bus_xfer(1, BASE, 32'hA5A5_0001, 4'hF, r);
      check("m2c_valid_1", 32'(m2c_valid), 32'd1);
      check("m2c_data_1", m2c_data, 32'hA5A5_0001);
      m2c_ready = 1; tick(); m2c_ready = 0;
      check("m2c_popped", 32'(m2c_valid), 32'd0);

      // overflow: five writes into a four-deep FIFO
      for (int unsigned i = 0; i < 5; i++) bus_xfer(1, BASE, 32'h100 + i, 4'hF, r);
      bus_xfer(0, BASE + 32'h8, '0, 4'hF, r);
      check("status_ovf", r, 32'h0004_0016);
      bus_xfer(1, BASE + 32'h8, 32'h10, 4'hF, r);
      bus_xfer(0, BASE + 32'h8, '0, 4'hF, r);
      check("status_ovf_clr", r, 32'h0004_0006);
      for (int unsigned i = 0; i < 4; i++) begin
         check("m2c_order", m2c_data, 32'h100 + i);
         m2c_ready = 1; tick(); m2c_ready = 0;
      end

      // C2M path, rx irq, underflow
      c2m_valid = 1; c2m_data = 32'h11; tick();
      c2m_data = 32'h22; tick();
      c2m_valid = 0;
      bus_xfer(1, BASE + 32'hC, 32'h1, 4'hF, r);
      check("irq_rx", 32'(irq), 32'd1);
      bus_xfer(0, BASE + 32'h4, '0, 4'hF, r);
      check("c2m_rd0", r, 32'h11);
      bus_xfer(0, BASE + 32'h4, '0, 4'hF, r);
      check("c2m_rd1", r, 32'h22);
      check("irq_clear", 32'(irq), 32'd0);
      bus_xfer(0, BASE + 32'h4, '0, 4'hF, r);
      check("c2m_rd_empty", r, 32'd0);
      bus_xfer(0, BASE + 32'h8, '0, 4'hF, r);
      check("status_unf", r, 32'h0000_0025);

      // out-of-window accesses are never acknowledged
      seen_ack = 0;
      stb = 1; cyc = 1; we = 1; sel = 4'hF; wdat = 32'h55;
      adr = BASE + 32'h10;
      for (int unsigned i = 0; i < 6; i++) begin tick(); seen_ack |= ack; end
      adr = 32'h3100_0000;
      for (int unsigned i = 0; i < 6; i++) begin tick(); seen_ack |= ack; end
      stb = 0; cyc = 0; we = 0;
      check("nohit_ack", 32'(seen_ack), 32'd0);

      // partial-byte write to M2C is acked but dropped
      bus_xfer(1, BASE, 32'hDEAD, 4'h3, r);
      bus_xfer(0, BASE + 32'h8, '0, 4'hF, r);
      check("sel3_level", r, 32'h0000_0025);

      // reset while a request is pending
      bus_xfer(1, BASE, 32'h77, 4'hF, r);
      stb = 1; cyc = 1; we = 1; adr = BASE; wdat = 32'h88; sel = 4'hF;
      #3 rst_n = 0;
      model_reset();
      seen_ack = 0;
      for (int unsigned i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         seen_ack |= ack;
      end
      check("rst_pending_ack", 32'(seen_ack), 32'd0);
      check("rst_m2c_valid", 32'(m2c_valid), 32'd0);
      stb = 0; cyc = 0; we = 0;
      #2 rst_n = 1;
      tick();
      bus_xfer(0, BASE + 32'h8, '0, 4'hF, r);
      check("status_after_rst", r, 32'h0000_0005);

      // randomized traffic
      for (int unsigned i = 0; i < 600; i++) begin
         stb = ($urandom_range(0, 3) != 0);
         cyc = stb ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
         we  = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 9))
            0, 1, 2: adr = BASE;
            3, 4:    adr = BASE + 32'h4;
            5:       adr = BASE + 32'h8;
            6:       adr = BASE + 32'hC;
            7:       adr = BASE + 32'h10;
            8:       adr = 32'h3100_0000;
            default: adr = BASE + 32'($urandom_range(0, 3)) * 4;
         endcase
         adr[1:0] = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0, 1:    sel = 4'hF;
            2:       sel = 4'h1;
            default: sel = 4'($urandom);
         endcase
         wdat      = $urandom;
         m2c_ready = ($urandom_range(0, 2) == 0);
         c2m_valid = ($urandom_range(0, 2) == 0);
         c2m_data  = $urandom;
         tick();
      end
      stb = 0; cyc = 0; we = 0; m2c_ready = 0; c2m_valid = 0;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
